// File: rtl/bpu_pkg.sv
// Shared types, default widths and the gshare index hash for the bpu_ghr slice.
package bpu_pkg;

  localparam int unsigned DEF_PHT_WIDTH  = 6;
  localparam int unsigned DEF_GHR_WIDTH  = 6;
  localparam int unsigned DEF_CKPT_DEPTH = 8;
  localparam int unsigned DEF_PC_WIDTH   = 32;

  // One in-flight prediction: the PHT index it used and the direction it predicted.
  typedef struct packed {
    logic [DEF_PHT_WIDTH-1:0] idx;
    logic                     pred;
  } ghr_ckpt_t;

  // gshare: word-aligned PC bits XOR zero-extended global history.
  function automatic logic [DEF_PHT_WIDTH-1:0] gshare_idx(
    input logic [DEF_PC_WIDTH-1:0]  pc,
    input logic [DEF_GHR_WIDTH-1:0] ghr
  );
    return pc[DEF_PHT_WIDTH+1:2] ^ DEF_PHT_WIDTH'(ghr);
  endfunction

endpackage

// File: rtl/bpu_ghr_if.sv
// Prediction / resolution / PHT-training bundle between the front end and bpu_ghr.
interface bpu_ghr_if
  import bpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = DEF_PC_WIDTH,
  parameter int unsigned PHT_WIDTH = DEF_PHT_WIDTH
);
  logic                 pred_valid;
  logic [PC_WIDTH-1:0]  pred_pc;
  logic                 pred_ready;
  logic [PHT_WIDTH-1:0] lookup_addr;
  logic                 pht_pred_taken;
  logic                 resolve_valid;
  logic                 resolve_taken;
  logic                 mispredict;
  logic                 branch_en;
  logic [PHT_WIDTH-1:0] update_addr;
  logic                 taken;
  logic                 flush;

  modport master (
    output pred_valid, pred_pc, pht_pred_taken, resolve_valid, resolve_taken, flush,
    input  pred_ready, lookup_addr, mispredict, branch_en, update_addr, taken
  );

  modport slave (
    input  pred_valid, pred_pc, pht_pred_taken, resolve_valid, resolve_taken, flush,
    output pred_ready, lookup_addr, mispredict, branch_en, update_addr, taken
  );
endinterface

// File: rtl/bpu_ghr_ckpt_fifo.sv
// In-order checkpoint FIFO of ghr_ckpt_t with push, pop and a clear that wins over both.
module bpu_ghr_ckpt_fifo
  import bpu_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_CKPT_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      clear_i,
  input  ghr_ckpt_t wdata_i,
  output logic      full_o,
  output logic      empty_o,
  output ghr_ckpt_t head_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  ghr_ckpt_t   mem_q [DEPTH];
  logic        push_ok, pop_ok;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o && !clear_i;

  // Pointer next-state; the extra MSB separates full from empty and wraps naturally.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clear_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + (AW+1)'(1);
      if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/bpu_ghr.sv
// gshare global-history stage: speculative/architectural GHR, checkpoint FIFO, PHT training.
// Optional BPU_GHR_STATS_EN adds prediction and misprediction counters.
module bpu_ghr
  import bpu_pkg::*;
#(
  parameter int unsigned PHT_WIDTH  = DEF_PHT_WIDTH,
  parameter int unsigned GHR_WIDTH  = DEF_GHR_WIDTH,
  parameter int unsigned CKPT_DEPTH = DEF_CKPT_DEPTH,
  parameter int unsigned PC_WIDTH   = DEF_PC_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  bpu_ghr_if.slave    bus
`ifdef BPU_GHR_STATS_EN
  ,
  output logic [31:0] stat_pred_cnt,
  output logic [31:0] stat_mispred_cnt
`endif
);
  logic [GHR_WIDTH-1:0] ghr_spec_q, ghr_spec_d;
  logic [GHR_WIDTH-1:0] ghr_arch_q, ghr_arch_d;
  logic                 branch_en_q, mispredict_q, taken_q;
  logic [PHT_WIDTH-1:0] update_addr_q;
  logic [PHT_WIDTH-1:0] lookup_addr_c;

  logic      full, empty, push, pop, mis, recover;
  ghr_ckpt_t head, wentry;

  assign lookup_addr_c = PHT_WIDTH'(gshare_idx(DEF_PC_WIDTH'(bus.pred_pc),
                                               DEF_GHR_WIDTH'(ghr_spec_q)));

  assign push    = bus.pred_valid && !full;
  assign pop     = bus.resolve_valid && !empty;
  assign mis     = pop && (bus.resolve_taken != head.pred);
  assign recover = mis || bus.flush;
  assign wentry  = '{idx: DEF_PHT_WIDTH'(lookup_addr_c), pred: bus.pht_pred_taken};

  assign bus.pred_ready  = !full;
  assign bus.lookup_addr = lookup_addr_c;
  assign bus.branch_en   = branch_en_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.update_addr = update_addr_q;
  assign bus.taken       = taken_q;

  bpu_ghr_ckpt_fifo #(.DEPTH(CKPT_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push && !recover),
    .pop_i   (pop),
    .clear_i (recover),
    .wdata_i (wentry),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  // History next-state; recovery restores speculative history from the updated architectural one.
  always_comb begin
    ghr_arch_d = ghr_arch_q;
    ghr_spec_d = ghr_spec_q;
    if (pop) ghr_arch_d = GHR_WIDTH'({ghr_arch_q, bus.resolve_taken});
    if (recover)   ghr_spec_d = ghr_arch_d;
    else if (push) ghr_spec_d = GHR_WIDTH'({ghr_spec_q, bus.pht_pred_taken});
  end

  // History registers and registered PHT training outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_spec_q    <= '0;
      ghr_arch_q    <= '0;
      branch_en_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      update_addr_q <= '0;
      taken_q       <= 1'b0;
    end else begin
      ghr_spec_q   <= ghr_spec_d;
      ghr_arch_q   <= ghr_arch_d;
      branch_en_q  <= pop;
      mispredict_q <= mis;
      if (pop) begin
        update_addr_q <= PHT_WIDTH'(head.idx);
        taken_q       <= bus.resolve_taken;
      end
    end
  end

`ifdef BPU_GHR_STATS_EN
  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pred_cnt    <= '0;
      stat_mispred_cnt <= '0;
    end else begin
      if (push) stat_pred_cnt    <= stat_pred_cnt + 32'd1;
      if (mis)  stat_mispred_cnt <= stat_mispred_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bpu_ghr.sv
// Self-checking bench for bpu_ghr: queue-based reference model, per-cycle compare, directed literals.
module tb_bpu_ghr;
  import bpu_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned GMASK = 63;
  localparam int unsigned PMASK = 63;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpu_ghr_if bus_if ();
`ifdef BPU_GHR_STATS_EN
  logic [31:0] stat_pred_cnt, stat_mispred_cnt;
`endif

  bpu_ghr dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef BPU_GHR_STATS_EN
    ,
    .stat_pred_cnt    (stat_pred_cnt),
    .stat_mispred_cnt (stat_mispred_cnt)
`endif
  );

  typedef struct {
    int unsigned idx;
    bit          pred;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_spec, m_arch, e_ua;
  bit          e_be, e_mis, e_tk;
  int unsigned m_pcnt, m_mcnt;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  bit          t_push, t_pop;
  ent_t        t_ent, t_head;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] pc, input int unsigned ghr);
    return ((int'(pc) >> 2) & PMASK) ^ ghr;
  endfunction

  // Reference model: advances on each clock edge from the inputs present at that edge.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_spec = 0; m_arch = 0;
      e_be = 0; e_mis = 0; e_ua = 0; e_tk = 0;
      m_pcnt = 0; m_mcnt = 0;
    end else begin
      t_push = bus_if.pred_valid && (mq.size() < DEPTH);
      t_pop  = bus_if.resolve_valid && (mq.size() > 0);
      t_ent.idx  = idx_of(bus_if.pred_pc, m_spec);
      t_ent.pred = bus_if.pht_pred_taken;
      e_be  = t_pop;
      e_mis = 0;
      if (t_pop) begin
        t_head = mq.pop_front();
        e_ua   = t_head.idx;
        e_tk   = bus_if.resolve_taken;
        e_mis  = (bus_if.resolve_taken != t_head.pred);
        m_arch = ((m_arch << 1) | int'(bus_if.resolve_taken)) & GMASK;
      end
      if (e_mis || bus_if.flush) begin
        mq.delete();
        m_spec = m_arch;
      end else if (t_push) begin
        mq.push_back(t_ent);
        m_spec = ((m_spec << 1) | int'(bus_if.pht_pred_taken)) & GMASK;
      end
      if (t_push) m_pcnt++;
      if (e_mis)  m_mcnt++;
    end
  end

  // Compare process: every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pred_ready", bus_if.pred_ready, mq.size() < DEPTH);
      if (bus_if.pred_valid)
        chk("lookup_addr", bus_if.lookup_addr, idx_of(bus_if.pred_pc, m_spec));
      chk("branch_en", bus_if.branch_en, e_be);
      chk("mispredict", bus_if.mispredict, e_mis);
      chk("update_addr", bus_if.update_addr, e_ua);
      chk("taken", bus_if.taken, e_tk);
`ifdef BPU_GHR_STATS_EN
      chk("stat_pred_cnt", stat_pred_cnt, m_pcnt);
      chk("stat_mispred_cnt", stat_mispred_cnt, m_mcnt);
`endif
    end
  end

  // One cycle: inputs applied just after the edge; returns with combinational outputs settled.
  task automatic cyc(input bit pv, input logic [31:0] pc, input bit pt,
                     input bit rv, input bit rt, input bit fl);
    @(posedge clk);
    #1;
    bus_if.pred_valid     = pv;
    bus_if.pred_pc        = pc;
    bus_if.pht_pred_taken = pt;
    bus_if.resolve_valid  = rv;
    bus_if.resolve_taken  = rt;
    bus_if.flush          = fl;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  initial begin
    bus_if.pred_valid = 0; bus_if.pred_pc = '0; bus_if.pht_pred_taken = 0;
    bus_if.resolve_valid = 0; bus_if.resolve_taken = 0; bus_if.flush = 0;
    idle(); idle();
    chk_en = 1'b1;
    rst = 1'b0;

    // Reset state and plain PC index.
    cyc(1'b0, 32'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lit_reset_ready", bus_if.pred_ready, 1);
    chk("lit_reset_branch_en", bus_if.branch_en, 0);
    chk("lit_reset_update_addr", bus_if.update_addr, 0);
    chk("lit_idx_1c", bus_if.lookup_addr, 7);

    // Push taken at 0x1C, then 0x20 sees history 1; resolve the first correctly.
    cyc(1'b1, 32'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lit_idx_20", bus_if.lookup_addr, 9);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    chk("lit_train_be", bus_if.branch_en, 1);
    chk("lit_train_addr", bus_if.update_addr, 7);
    chk("lit_train_taken", bus_if.taken, 1);
    chk("lit_train_mis", bus_if.mispredict, 0);

    // Fill to full; a rejected push leaves history alone.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk("lit_full_ready", bus_if.pred_ready, 0);
    chk("lit_full_ghr", bus_if.lookup_addr, 6'h3F);
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("lit_full_ghr_kept", bus_if.lookup_addr, 6'h3F);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("lit_after_pop_ready", bus_if.pred_ready, 1);
    idle();
    chk("lit_pushpop_ready", bus_if.pred_ready, 1);
    chk("lit_pushpop_ghr", bus_if.lookup_addr, 6'h3E);
    cyc(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk("lit_refull_ready", bus_if.pred_ready, 0);

    // Mispredict recovery clears FIFO and restores history; an empty resolve is ignored.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("lit_mis", bus_if.mispredict, 1);
    chk("lit_mis_taken", bus_if.taken, 0);
    chk("lit_mis_ghr", bus_if.lookup_addr, 0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    chk("lit_empty_resolve_be", bus_if.branch_en, 0);

    // Flush with a same-cycle correct pop and a discarded push.
    do_reset();
    cyc(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk("lit_pre_flush_ghr", bus_if.lookup_addr, 6'h0B);
    cyc(1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle();
    chk("lit_flush_be", bus_if.branch_en, 1);
    chk("lit_flush_mis", bus_if.mispredict, 0);
    chk("lit_flush_ghr", bus_if.lookup_addr, 1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    chk("lit_flush_empty", bus_if.branch_en, 0);

`ifdef BPU_GHR_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("lit_stat_pred", stat_pred_cnt, 5);
    chk("lit_stat_mis", stat_mispred_cnt, 1);
    do_reset();
    chk("lit_stat_pred_rst", stat_pred_cnt, 0);
    chk("lit_stat_mis_rst", stat_mispred_cnt, 0);
`endif

    // Randomized traffic with occasional flush and mid-run reset.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 299) == 0);
      bus_if.pred_valid     = $urandom_range(0, 1) == 1;
      bus_if.pred_pc        = $urandom;
      bus_if.pht_pred_taken = $urandom_range(0, 1) == 1;
      bus_if.resolve_valid  = $urandom_range(0, 2) == 0;
      bus_if.resolve_taken  = $urandom_range(0, 1) == 1;
      bus_if.flush          = $urandom_range(0, 24) == 0;
    end
    rst = 1'b0;
    idle();
    idle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
